// File: rtl/nd_arb2_if.sv
// Message channel bundle for the two-input arbiter: two upstream 4-phase
// requesters (rcv0, rcv1) and one downstream 4-phase sender (snd0).
//   slave  : arbiter view (takes rcvN_*, drives rcvN_ack and snd0_*)
//   master : environment view (drives rcvN_* and snd0_ack)
interface nd_arb2_if #(
  parameter int unsigned ASZ = 8,
  parameter int unsigned DSZ = 8,
  parameter int unsigned RSZ = 4
);
  logic           rcv0_req;
  logic           rcv0_ack;
  logic [ASZ-1:0] rcv0_addr;
  logic [DSZ-1:0] rcv0_dat;
  logic [RSZ-1:0] rcv0_red;

  logic           rcv1_req;
  logic           rcv1_ack;
  logic [ASZ-1:0] rcv1_addr;
  logic [DSZ-1:0] rcv1_dat;
  logic [RSZ-1:0] rcv1_red;

  logic           snd0_req;
  logic           snd0_ack;
  logic [ASZ-1:0] snd0_addr;
  logic [DSZ-1:0] snd0_dat;
  logic [RSZ-1:0] snd0_red;

  modport slave (
    input  rcv0_req, rcv0_addr, rcv0_dat, rcv0_red,
    output rcv0_ack,
    input  rcv1_req, rcv1_addr, rcv1_dat, rcv1_red,
    output rcv1_ack,
    output snd0_req, snd0_addr, snd0_dat, snd0_red,
    input  snd0_ack
  );

  modport master (
    output rcv0_req, rcv0_addr, rcv0_dat, rcv0_red,
    input  rcv0_ack,
    output rcv1_req, rcv1_addr, rcv1_dat, rcv1_red,
    input  rcv1_ack,
    input  snd0_req, snd0_addr, snd0_dat, snd0_red,
    output snd0_ack
  );
endinterface

// File: rtl/nd_arb2.sv
// Two-input round-robin arbiter feeding one 4-phase message channel.
// Holds at most one message: latches it from the granted requester, acks
// the requester, then runs a full req/ack cycle on snd0.
// Ports:
//   i_clk  : clock, all state changes on rising edge
//   reset  : asynchronous, active-low
//   ready  : high once initialised after reset
//   bus    : nd_arb2_if.slave (rcv0_*, rcv1_*, snd0_*)
module nd_arb2 #(
  parameter int unsigned ASZ = 8,
  parameter int unsigned DSZ = 8,
  parameter int unsigned RSZ = 4
) (
  input  logic       i_clk,
  input  logic       reset,
  output logic       ready,
  nd_arb2_if.slave   bus
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_SEND    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t         state_q;
  logic           last_q;
  logic           ack0_q;
  logic           ack1_q;
  logic           sreq_q;
  logic [ASZ-1:0] addr_q;
  logic [DSZ-1:0] dat_q;
  logic [RSZ-1:0] red_q;

  logic elig0;
  logic elig1;
  logic pick0;
  logic pick1;

  // A requester whose previous message is still being acknowledged is not eligible.
  assign elig0 = bus.rcv0_req & ~ack0_q;
  assign elig1 = bus.rcv1_req & ~ack1_q;

  // On a tie the input that did not win last time is granted.
  assign pick1 = elig1 & (~elig0 | ~last_q);
  assign pick0 = elig0 & ~pick1;

  assign bus.rcv0_ack  = ack0_q;
  assign bus.rcv1_ack  = ack1_q;
  assign bus.snd0_req  = sreq_q;
  assign bus.snd0_addr = addr_q;
  assign bus.snd0_dat  = dat_q;
  assign bus.snd0_red  = red_q;

  // Output-side FSM plus independent input-side ack release.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      last_q  <= 1'b1;
      ready   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      sreq_q  <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
      red_q   <= '0;
    end else begin
      // Release is evaluated every cycle; a grant only targets an input whose
      // ack is low, so it never collides with a release of the same input.
      if (ack0_q && !bus.rcv0_req) ack0_q <= 1'b0;
      if (ack1_q && !bus.rcv1_req) ack1_q <= 1'b0;

      case (state_q)
        S_INIT: begin
          ready   <= 1'b1;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (pick0) begin
            addr_q  <= bus.rcv0_addr;
            dat_q   <= bus.rcv0_dat;
            red_q   <= bus.rcv0_red;
            ack0_q  <= 1'b1;
            sreq_q  <= 1'b1;
            last_q  <= 1'b0;
            state_q <= S_SEND;
          end else if (pick1) begin
            addr_q  <= bus.rcv1_addr;
            dat_q   <= bus.rcv1_dat;
            red_q   <= bus.rcv1_red;
            ack1_q  <= 1'b1;
            sreq_q  <= 1'b1;
            last_q  <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.snd0_ack) begin
            sreq_q  <= 1'b0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!bus.snd0_ack) state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_nd_arb2.sv
// Self-checking bench for nd_arb2: directed scenarios plus randomized
// traffic, checked against a transaction-level round-robin model.
module tb_nd_arb2;

  localparam int unsigned ASZ = 8;
  localparam int unsigned DSZ = 8;
  localparam int unsigned RSZ = 4;

  typedef struct packed {
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_t;

  logic i_clk;
  logic reset;
  logic ready;

  nd_arb2_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) bus ();

  nd_arb2 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .i_clk (i_clk),
    .reset (reset),
    .ready (ready),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Environment state: upstream senders, downstream receiver.
  msg_t tx_q [2][$];
  msg_t rx [$];
  logic up_req [2];
  msg_t up_msg [2];
  int   up_st [2];
  int   up_cnt [2];
  int   rel_delay [2];
  logic ds_ack;
  logic ds_hold;
  logic ds_rand;
  int   ds_delay;
  int   ds_cnt;
  int   ds_cur;

  int n_checks = 0;
  int n_errors = 0;

  assign bus.rcv0_req  = up_req[0];
  assign bus.rcv0_addr = up_msg[0].addr;
  assign bus.rcv0_dat  = up_msg[0].dat;
  assign bus.rcv0_red  = up_msg[0].red;
  assign bus.rcv1_req  = up_req[1];
  assign bus.rcv1_addr = up_msg[1].addr;
  assign bus.rcv1_dat  = up_msg[1].dat;
  assign bus.rcv1_red  = up_msg[1].red;
  assign bus.snd0_ack  = ds_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic msg_t snd_msg();
    return {bus.snd0_addr, bus.snd0_dat, bus.snd0_red};
  endfunction

  function automatic bit quiet();
    return !bus.snd0_req && !bus.rcv0_ack && !bus.rcv1_ack && !ds_ack &&
           up_st[0] == 0 && up_st[1] == 0 &&
           tx_q[0].size() == 0 && tx_q[1].size() == 0;
  endfunction

  // Round-robin model: alternate while both sources still have messages,
  // starting with the source that did not win last, then drain the other.
  function automatic void merge(input msg_t a[$], input msg_t b[$], input bit last,
                                output msg_t o[$]);
    int i = 0;
    int j = 0;
    bit pick;
    o.delete();
    while (i < a.size() || j < b.size()) begin
      if (i < a.size() && j < b.size()) pick = ~last;
      else pick = (i < a.size()) ? 1'b0 : 1'b1;
      if (pick == 1'b0) begin o.push_back(a[i]); i++; end
      else begin o.push_back(b[j]); j++; end
      last = pick;
    end
  endfunction

  task automatic check_rx(input string tag, input msg_t expv[$]);
    check({tag, "_count"}, 32'(rx.size()), 32'(expv.size()));
    for (int i = 0; i < expv.size() && i < rx.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(rx[i]), 32'(expv[i]));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (quiet()) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_sreq(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.snd0_req) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge i_clk);
    #2 reset = 1'b0;
    repeat (cycles) @(posedge i_clk);
    tx_q[0].delete();
    tx_q[1].delete();
    rx.delete();
    ds_hold = 1'b0;
    ds_rand = 1'b0;
    ds_delay = 0;
    rel_delay[0] = 0;
    rel_delay[1] = 0;
    @(negedge i_clk);
    #2 reset = 1'b1;
    tick();
    check("reinit_ready", 32'(ready), 32'd1);
  endtask

  // Bus functional models, acting on the falling edge.
  initial begin
    bit a_n;
    up_req[0] = 1'b0; up_req[1] = 1'b0;
    up_msg[0] = '0;   up_msg[1] = '0;
    up_st[0] = 0;     up_st[1] = 0;
    up_cnt[0] = 0;    up_cnt[1] = 0;
    ds_ack = 1'b0; ds_cnt = 0; ds_cur = 0;
    forever begin
      @(negedge i_clk);
      if (!reset) begin
        up_req[0] = 1'b0; up_req[1] = 1'b0;
        up_st[0] = 0;     up_st[1] = 0;
        ds_ack = 1'b0;    ds_cnt = 0;
      end else begin
        for (int n = 0; n < 2; n++) begin
          a_n = (n == 0) ? bus.rcv0_ack : bus.rcv1_ack;
          if (up_st[n] == 1 && a_n) begin
            if (up_cnt[n] >= rel_delay[n]) begin
              up_req[n] = 1'b0;
              if (tx_q[n].size() > 0) void'(tx_q[n].pop_front());
              up_st[n] = 2;
            end else up_cnt[n]++;
          end else if (up_st[n] == 2 && !a_n) begin
            up_st[n] = 0;
          end
          if (up_st[n] == 0 && !a_n && tx_q[n].size() > 0) begin
            up_msg[n] = tx_q[n][0];
            up_req[n] = 1'b1;
            up_cnt[n] = 0;
            up_st[n]  = 1;
          end
        end
        if (ds_ack) begin
          if (!bus.snd0_req) ds_ack = 1'b0;
        end else if (bus.snd0_req && !ds_hold) begin
          if (ds_cnt == 0) ds_cur = ds_rand ? int'($urandom_range(3, 0)) : ds_delay;
          if (ds_cnt >= ds_cur) begin
            ds_ack = 1'b1;
            ds_cnt = 0;
            rx.push_back({bus.snd0_addr, bus.snd0_dat, bus.snd0_red});
          end else ds_cnt++;
        end
      end
    end
  end

  initial begin
    msg_t m, ma, mb, mc, md, me;
    msg_t q0[$];
    msg_t q1[$];
    msg_t expv[$];
    bit prev_sreq, seen, prev1, ack0_at;
    int n0, n1;

    reset = 1'b0;
    ds_hold = 1'b0; ds_rand = 1'b0; ds_delay = 0;
    rel_delay[0] = 0; rel_delay[1] = 0;

    // Reset and ready
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rst_ready_%0d", c), 32'(ready), 32'd0);
      check($sformatf("rst_sreq_%0d", c), 32'(bus.snd0_req), 32'd0);
      check($sformatf("rst_ack0_%0d", c), 32'(bus.rcv0_ack), 32'd0);
      check($sformatf("rst_ack1_%0d", c), 32'(bus.rcv1_ack), 32'd0);
    end
    @(negedge i_clk);
    #2 reset = 1'b1;
    #1 check("rel_ready_before_edge", 32'(ready), 32'd0);
    tick();
    check("rel_ready_after_edge", 32'(ready), 32'd1);
    check("rel_no_grant", 32'(bus.snd0_req), 32'd0);

    // Single message, downstream acks two clocks after request
    m = '{addr: 8'h03, dat: 8'hA5, red: 4'h1};
    ds_delay = 2;
    expv.delete(); expv.push_back(m);
    tx_q[0].push_back(m);
    prev_sreq = bus.snd0_req;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rcv0_ack) begin seen = 1'b1; break; end
      prev_sreq = bus.snd0_req;
    end
    check("single_grant", 32'(seen), 32'd1);
    check("single_sreq_with_ack", 32'(bus.snd0_req), 32'd1);
    check("single_sreq_was_low", 32'(prev_sreq), 32'd0);
    check("single_payload", 32'(snd_msg()), 32'(m));
    wait_idle("single_done", 100);
    check_rx("single_rx", expv);

    // Tie and fairness from a fresh reset
    do_reset(2);
    q0.delete(); q1.delete();
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{addr: 8'(k), dat: 8'(8'h10 + k), red: 4'(k)});
      q1.push_back('{addr: 8'(8 + k), dat: 8'(8'h20 + k), red: 4'(k + 4)});
    end
    foreach (q0[i]) tx_q[0].push_back(q0[i]);
    foreach (q1[i]) tx_q[1].push_back(q1[i]);
    wait_idle("tie_done", 200);
    merge(q0, q1, 1'b1, expv);
    check_rx("tie_rx", expv);
    for (int i = 0; i < 8 && i < rx.size(); i++)
      check($sformatf("tie_dat_%0d", i), 32'(rx[i].dat),
            32'(((i % 2) == 1 ? 8'h20 : 8'h10) + 8'(i / 2)));

    // Back-pressure: downstream stalls while rcv1 keeps requesting
    rx.delete();
    ds_hold = 1'b1;
    ma = '{addr: 8'h41, dat: 8'h55, red: 4'h2};
    mb = '{addr: 8'h42, dat: 8'h66, red: 4'h3};
    tx_q[1].push_back(ma);
    wait_sreq("bp_first_req");
    check("bp_payload", 32'(snd_msg()), 32'(ma));
    tx_q[1].push_back(mb);
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("bp_sreq_%0d", c), 32'(bus.snd0_req), 32'd1);
      check($sformatf("bp_hold_%0d", c), 32'(snd_msg()), 32'(ma));
    end
    check("bp_rcv1_waiting", 32'(bus.rcv1_req), 32'd1);
    check("bp_no_regrant", 32'(bus.rcv1_ack), 32'd0);
    ds_hold = 1'b0;
    wait_idle("bp_done", 100);
    expv.delete(); expv.push_back(ma); expv.push_back(mb);
    check_rx("bp_rx", expv);

    // Slow upstream release on rcv0 while rcv1 is pending
    rx.delete();
    rel_delay[0] = 10;
    mc = '{addr: 8'h0C, dat: 8'hC1, red: 4'h5};
    md = '{addr: 8'h0D, dat: 8'hD1, red: 4'h6};
    me = '{addr: 8'h0E, dat: 8'hE1, red: 4'h7};
    q0.delete(); q1.delete();
    q0.push_back(mc); q0.push_back(me); q1.push_back(md);
    tx_q[0].push_back(mc); tx_q[0].push_back(me); tx_q[1].push_back(md);
    seen = 1'b0; ack0_at = 1'b0; prev1 = bus.rcv1_ack;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!prev1 && bus.rcv1_ack && !seen) begin seen = 1'b1; ack0_at = bus.rcv0_ack; end
      prev1 = bus.rcv1_ack;
      if (quiet()) break;
    end
    check("slow_rcv1_granted", 32'(seen), 32'd1);
    check("slow_rcv1_while_ack0", 32'(ack0_at), 32'd1);
    check("slow_done", 32'(quiet()), 32'd1);
    merge(q0, q1, 1'b1, expv);
    check_rx("slow_rx", expv);
    rel_delay[0] = 0;

    // Randomized traffic with random downstream latency
    for (int it = 0; it < 3; it++) begin
      do_reset(2);
      ds_rand = 1'b1;
      n0 = int'($urandom_range(8, 2));
      n1 = int'($urandom_range(8, 2));
      q0.delete(); q1.delete();
      for (int k = 0; k < n0; k++) q0.push_back(msg_t'($urandom));
      for (int k = 0; k < n1; k++) q1.push_back(msg_t'($urandom));
      foreach (q0[i]) tx_q[0].push_back(q0[i]);
      foreach (q1[i]) tx_q[1].push_back(q1[i]);
      wait_idle($sformatf("rand%0d_done", it), 400);
      merge(q0, q1, 1'b1, expv);
      check_rx($sformatf("rand%0d_rx", it), expv);
    end
    ds_rand = 1'b0;

    // Reset asserted while a message is outstanding downstream
    rx.delete();
    ds_hold = 1'b1;
    tx_q[0].push_back('{addr: 8'h77, dat: 8'h88, red: 4'h9});
    wait_sreq("mid_in_send");
    @(negedge i_clk);
    #2 reset = 1'b0;
    #1;
    check("mid_sreq", 32'(bus.snd0_req), 32'd0);
    check("mid_ack0", 32'(bus.rcv0_ack), 32'd0);
    check("mid_ack1", 32'(bus.rcv1_ack), 32'd0);
    check("mid_ready", 32'(ready), 32'd0);
    check("mid_payload_clear", 32'(snd_msg()), 32'd0);
    repeat (2) @(posedge i_clk);
    tx_q[0].delete(); tx_q[1].delete(); rx.delete();
    ds_hold = 1'b0;
    @(negedge i_clk);
    #2 reset = 1'b1;
    tick();
    check("mid_ready_after", 32'(ready), 32'd1);
    ma = '{addr: 8'h51, dat: 8'h5A, red: 4'hA};
    mb = '{addr: 8'h61, dat: 8'h6B, red: 4'hB};
    tx_q[0].push_back(ma); tx_q[1].push_back(mb);
    wait_idle("mid_tie_done", 100);
    expv.delete(); expv.push_back(ma); expv.push_back(mb);
    check_rx("mid_tie_rx", expv);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
